// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state types and constants for the UART endpoint
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {RD_IDLE, RD_ACK, RD_WAIT_LOW} rd_state_t;

endpackage

// File: rtl/byte_fifo.sv
// rtl/byte_fifo.sv - power-of-two byte FIFO with combinational read data
module byte_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = UART_DATA_BITS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] pushData,
  input  logic             pop,
  output logic [WIDTH-1:0] popData,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == DEPTH_C);
  assign popData = mem_q[rd_ptr_q];

  // A pop frees its slot first, so a push into a full FIFO is accepted alongside a pop.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= pushData;
  end

endmodule

// File: rtl/uart_endpoint.sv
// rtl/uart_endpoint.sv - CPU-facing UART responder: buffered 8N1 transmitter and receiver
module uart_endpoint
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      uartReadReq,
  output logic                      uartReadAck,
  output logic [UART_DATA_BITS-1:0] uartReadData,
  input  logic                      uartWriteReq,
  input  logic [UART_DATA_BITS-1:0] uartWriteData,
  output logic                      uartWriteReady,
  input  logic                      rx,
  output logic                      tx,
  output logic                      rxOverrun,
  output logic                      rxFrameErr
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_MID  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]    BIT_LAST = 3'(UART_DATA_BITS - 1);

  tx_state_t                 tx_state_q, tx_state_d;
  logic [CW-1:0]             tx_cnt_q, tx_cnt_d;
  logic [2:0]                tx_bit_q, tx_bit_d;
  logic [UART_DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic                      tx_q, tx_d;
  logic                      tx_pop, tx_push, tx_full, tx_empty;
  logic [UART_DATA_BITS-1:0] tx_pop_data;

  logic                      rx_meta_q, rx_sync_q;
  rx_state_t                 rx_state_q, rx_state_d;
  logic [CW-1:0]             rx_cnt_q, rx_cnt_d;
  logic [2:0]                rx_bit_q, rx_bit_d;
  logic [UART_DATA_BITS-1:0] rx_shift_q, rx_shift_d;
  logic                      rx_wait_high_q, rx_wait_high_d;
  logic                      overrun_q, overrun_d;
  logic                      frame_err_q, frame_err_d;
  logic                      rx_push, rx_full, rx_empty;
  logic [UART_DATA_BITS-1:0] rx_pop_data;

  rd_state_t                 rd_state_q, rd_state_d;
  logic [UART_DATA_BITS-1:0] rd_data_q, rd_data_d;
  logic                      rd_pop;

  assign uartWriteReady = !tx_full;
  assign tx_push        = uartWriteReq && !tx_full;
  assign tx             = tx_q;
  assign rxOverrun      = overrun_q;
  assign rxFrameErr     = frame_err_q;
  assign uartReadAck    = (rd_state_q == RD_ACK);
  assign uartReadData   = rd_data_q;

  byte_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(UART_DATA_BITS)) u_tx_fifo (
    .clk(clk), .reset(reset),
    .push(tx_push), .pushData(uartWriteData),
    .pop(tx_pop), .popData(tx_pop_data),
    .full(tx_full), .empty(tx_empty)
  );

  byte_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(UART_DATA_BITS)) u_rx_fifo (
    .clk(clk), .reset(reset),
    .push(rx_push), .pushData(rx_shift_q),
    .pop(rd_pop), .popData(rx_pop_data),
    .full(rx_full), .empty(rx_empty)
  );

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_pop     = 1'b0;
    case (tx_state_q)
      TX_IDLE: if (!tx_empty) begin
        tx_pop     = 1'b1;
        tx_shift_d = tx_pop_data;
        tx_cnt_d   = '0;
        tx_state_d = TX_START;
      end
      TX_START: if (tx_cnt_q == CNT_LAST) begin
        tx_cnt_d   = '0;
        tx_bit_d   = '0;
        tx_state_d = TX_DATA;
      end else tx_cnt_d = tx_cnt_q + 1'b1;
      TX_DATA: if (tx_cnt_q == CNT_LAST) begin
        tx_cnt_d   = '0;
        tx_shift_d = tx_shift_q >> 1;
        if (tx_bit_q == BIT_LAST) tx_state_d = TX_STOP;
        else tx_bit_d = tx_bit_q + 1'b1;
      end else tx_cnt_d = tx_cnt_q + 1'b1;
      TX_STOP: if (tx_cnt_q == CNT_LAST) begin
        tx_cnt_d   = '0;
        tx_state_d = TX_IDLE;
      end else tx_cnt_d = tx_cnt_q + 1'b1;
      default: tx_state_d = TX_IDLE;
    endcase
    // Line level is registered from the next state so tx is glitch-free.
    tx_d = 1'b1;
    if (tx_state_d == TX_START)     tx_d = 1'b0;
    else if (tx_state_d == TX_DATA) tx_d = tx_shift_d[0];
  end

  always_comb begin
    rx_state_d     = rx_state_q;
    rx_cnt_d       = rx_cnt_q;
    rx_bit_d       = rx_bit_q;
    rx_shift_d     = rx_shift_q;
    rx_wait_high_d = rx_wait_high_q;
    overrun_d      = overrun_q;
    frame_err_d    = frame_err_q;
    rx_push        = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_wait_high_q) begin
          if (rx_sync_q) rx_wait_high_d = 1'b0;
        end else if (!rx_sync_q) begin
          rx_cnt_d   = '0;
          rx_state_d = RX_START;
        end
      end
      RX_START: if (rx_cnt_q == CNT_MID) begin
        rx_cnt_d   = '0;
        rx_bit_d   = '0;
        rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
      end else rx_cnt_d = rx_cnt_q + 1'b1;
      RX_DATA: if (rx_cnt_q == CNT_LAST) begin
        rx_cnt_d   = '0;
        rx_shift_d = {rx_sync_q, rx_shift_q[UART_DATA_BITS-1:1]};
        if (rx_bit_q == BIT_LAST) rx_state_d = RX_STOP;
        else rx_bit_d = rx_bit_q + 1'b1;
      end else rx_cnt_d = rx_cnt_q + 1'b1;
      RX_STOP: if (rx_cnt_q == CNT_LAST) begin
        rx_cnt_d   = '0;
        rx_state_d = RX_IDLE;
        if (rx_sync_q) begin
          rx_push = 1'b1;
          if (rx_full && !rd_pop) overrun_d = 1'b1;
        end else begin
          frame_err_d    = 1'b1;
          rx_wait_high_d = 1'b1;
        end
      end else rx_cnt_d = rx_cnt_q + 1'b1;
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_comb begin
    rd_state_d = rd_state_q;
    rd_data_d  = rd_data_q;
    rd_pop     = 1'b0;
    case (rd_state_q)
      RD_IDLE: if (uartReadReq && !rx_empty) begin
        rd_pop     = 1'b1;
        rd_data_d  = rx_pop_data;
        rd_state_d = RD_ACK;
      end
      RD_ACK:      rd_state_d = RD_WAIT_LOW;
      RD_WAIT_LOW: if (!uartReadReq) rd_state_d = RD_IDLE;
      default:     rd_state_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state_q     <= TX_IDLE;
      tx_cnt_q       <= '0;
      tx_bit_q       <= '0;
      tx_shift_q     <= '0;
      tx_q           <= 1'b1;
      rx_meta_q      <= 1'b1;
      rx_sync_q      <= 1'b1;
      rx_state_q     <= RX_IDLE;
      rx_cnt_q       <= '0;
      rx_bit_q       <= '0;
      rx_shift_q     <= '0;
      rx_wait_high_q <= 1'b0;
      overrun_q      <= 1'b0;
      frame_err_q    <= 1'b0;
      rd_state_q     <= RD_IDLE;
      rd_data_q      <= '0;
    end else begin
      tx_state_q     <= tx_state_d;
      tx_cnt_q       <= tx_cnt_d;
      tx_bit_q       <= tx_bit_d;
      tx_shift_q     <= tx_shift_d;
      tx_q           <= tx_d;
      rx_meta_q      <= rx;
      rx_sync_q      <= rx_meta_q;
      rx_state_q     <= rx_state_d;
      rx_cnt_q       <= rx_cnt_d;
      rx_bit_q       <= rx_bit_d;
      rx_shift_q     <= rx_shift_d;
      rx_wait_high_q <= rx_wait_high_d;
      overrun_q      <= overrun_d;
      frame_err_q    <= frame_err_d;
      rd_state_q     <= rd_state_d;
      rd_data_q      <= rd_data_d;
    end
  end

endmodule

// File: tb/tb_uart_endpoint.sv
// tb/tb_uart_endpoint.sv - self-checking bench for uart_endpoint with a line-level reference model
module tb_uart_endpoint;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       uartReadReq = 1'b0;
  logic       uartReadAck;
  logic [7:0] uartReadData;
  logic       uartWriteReq = 1'b0;
  logic [7:0] uartWriteData = 8'h00;
  logic       uartWriteReady;
  logic       rx = 1'b1;
  logic       tx;
  logic       rxOverrun;
  logic       rxFrameErr;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  logic [7:0] line_q[$];
  int         start_q[$];

  uart_endpoint #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .uartReadReq(uartReadReq), .uartReadAck(uartReadAck), .uartReadData(uartReadData),
    .uartWriteReq(uartWriteReq), .uartWriteData(uartWriteData), .uartWriteReady(uartWriteReady),
    .rx(rx), .tx(tx), .rxOverrun(rxOverrun), .rxFrameErr(rxFrameErr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Decodes every frame seen on tx by mid-bit sampling, recording data and start cycle.
  initial begin : tx_monitor
    logic [7:0] b;
    int t;
    forever begin
      step();
      if (tx === 1'b0) begin
        t = cyc;
        step(CPB / 2);
        for (int k = 0; k < 8; k++) begin
          step(CPB);
          b[k] = tx;
        end
        step(CPB);
        line_q.push_back(b);
        start_q.push_back(t);
      end
    end
  end

  task automatic write_byte(input logic [7:0] d);
    uartWriteReq  = 1'b1;
    uartWriteData = d;
    step();
    uartWriteReq  = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] d, input logic stop_bit);
    rx = 1'b0;
    step(CPB);
    for (int k = 0; k < 8; k++) begin
      rx = d[k];
      step(CPB);
    end
    rx = stop_bit;
    step(CPB);
    rx = 1'b1;
    step(2 * CPB);
  endtask

  // lat = samples until ack (0 = first cycle after req), -1 when no ack within the budget.
  task automatic read_byte(output logic [7:0] d, output int lat);
    d   = 8'h00;
    lat = -1;
    uartReadReq = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (uartReadAck === 1'b1) begin
        d   = uartReadData;
        lat = i;
        break;
      end
    end
    uartReadReq = 1'b0;
    step(2);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(3);
    n_checks++; if (tx !== 1'b1) begin n_errors++; $display("FAIL reset_tx got=%b want=1", tx); end
    n_checks++; if (uartReadAck !== 1'b0) begin n_errors++; $display("FAIL reset_ack got=%b want=0", uartReadAck); end
    n_checks++; if (uartReadData !== 8'h00) begin n_errors++; $display("FAIL reset_rdata got=%h want=00", uartReadData); end
    n_checks++; if (uartWriteReady !== 1'b1) begin n_errors++; $display("FAIL reset_wready got=%b want=1", uartWriteReady); end
    n_checks++; if (rxOverrun !== 1'b0) begin n_errors++; $display("FAIL reset_overrun got=%b want=0", rxOverrun); end
    n_checks++; if (rxFrameErr !== 1'b0) begin n_errors++; $display("FAIL reset_frameerr got=%b want=0", rxFrameErr); end
    reset = 1'b0;
    step(2);
  endtask

  task automatic test_tx_single();
    logic [7:0] d;
    logic       exp_bit;
    int         idx;
    d = 8'hA5;
    line_q.delete();
    start_q.delete();
    write_byte(d);
    n_checks++; if (tx !== 1'b1) begin n_errors++; $display("FAIL tx_pop_cycle got=%b want=1", tx); end
    step();
    for (int i = 0; i <= FRAME; i++) begin
      idx = i / CPB;
      if (idx == 0)      exp_bit = 1'b0;
      else if (idx <= 8) exp_bit = d[idx-1];
      else               exp_bit = 1'b1;
      n_checks++; if (tx !== exp_bit) begin n_errors++; $display("FAIL tx_wave cycle=%0d got=%b want=%b", i, tx, exp_bit); end
      step();
    end
    n_checks++; if (line_q.size() != 1 || line_q[0] !== d) begin n_errors++; $display("FAIL tx_single_decode frames=%0d want 1 frame of %h", line_q.size(), d); end
  endtask

  task automatic test_tx_backpressure();
    logic [7:0] exp_q[$];
    int  nbuf;
    bit  busy;
    bit  exp_ready;
    step(5);
    line_q.delete();
    start_q.delete();
    nbuf = 0;
    busy = 0;
    for (int w = 1; w <= 6; w++) begin
      // Idle transmitter takes the oldest buffered byte on the edge after it arrives.
      if (!busy && nbuf > 0) begin nbuf--; busy = 1; end
      exp_ready = (nbuf < DEPTH);
      n_checks++; if (uartWriteReady !== exp_ready) begin n_errors++; $display("FAIL bp_ready write=%0d got=%b want=%b", w, uartWriteReady, exp_ready); end
      uartWriteReq  = 1'b1;
      uartWriteData = 8'(w);
      if (exp_ready) begin nbuf++; exp_q.push_back(8'(w)); end
      step();
    end
    uartWriteReq = 1'b0;
    for (int i = 0; i < 8 * FRAME && line_q.size() < exp_q.size(); i++) step();
    step(2 * FRAME);
    n_checks++; if (line_q.size() != exp_q.size()) begin n_errors++; $display("FAIL bp_count got=%0d want=%0d", line_q.size(), exp_q.size()); end
    for (int k = 0; k < exp_q.size() && k < line_q.size(); k++) begin
      n_checks++; if (line_q[k] !== exp_q[k]) begin n_errors++; $display("FAIL bp_byte idx=%0d got=%h want=%h", k, line_q[k], exp_q[k]); end
    end
    for (int k = 1; k < start_q.size(); k++) begin
      n_checks++; if (start_q[k] - start_q[k-1] != FRAME + 1) begin n_errors++; $display("FAIL bp_spacing idx=%0d got=%0d want=%0d", k, start_q[k] - start_q[k-1], FRAME + 1); end
    end
  endtask

  task automatic test_tx_random();
    logic [7:0] exp_q[$];
    logic [7:0] d;
    line_q.delete();
    start_q.delete();
    for (int k = 0; k < 3; k++) begin
      d = 8'($urandom);
      exp_q.push_back(d);
      write_byte(d);
      step($urandom_range(0, 60));
    end
    for (int i = 0; i < 6 * FRAME && line_q.size() < 3; i++) step();
    n_checks++; if (line_q.size() != 3) begin n_errors++; $display("FAIL txrand_count got=%0d want=3", line_q.size()); end
    for (int k = 0; k < 3 && k < line_q.size(); k++) begin
      n_checks++; if (line_q[k] !== exp_q[k]) begin n_errors++; $display("FAIL txrand_byte idx=%0d got=%h want=%h", k, line_q[k], exp_q[k]); end
    end
  endtask

  task automatic test_rx_read();
    logic [7:0] exp_q[$];
    logic [7:0] d;
    int lat;
    int extra_acks;
    send_rx(8'h3C, 1'b1);
    step(4);
    uartReadReq = 1'b1;
    lat = -1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (uartReadAck === 1'b1) begin lat = i; break; end
    end
    n_checks++; if (lat != 0) begin n_errors++; $display("FAIL rd_latency got=%0d want=0", lat); end
    n_checks++; if (uartReadData !== 8'h3C) begin n_errors++; $display("FAIL rd_data got=%h want=3c", uartReadData); end
    extra_acks = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (uartReadAck !== 1'b0) extra_acks++;
    end
    n_checks++; if (extra_acks != 0) begin n_errors++; $display("FAIL rd_single_ack got=%0d want=0", extra_acks); end
    n_checks++; if (uartReadData !== 8'h3C) begin n_errors++; $display("FAIL rd_data_hold got=%h want=3c", uartReadData); end
    uartReadReq = 1'b0;
    step(2);
    for (int k = 0; k < 3; k++) begin
      d = 8'($urandom);
      exp_q.push_back(d);
      send_rx(d, 1'b1);
    end
    for (int k = 0; k < 3; k++) begin
      read_byte(d, lat);
      n_checks++; if (lat < 0 || d !== exp_q[k]) begin n_errors++; $display("FAIL rd_rand idx=%0d got=%h lat=%0d want=%h", k, d, lat, exp_q[k]); end
    end
  endtask

  task automatic test_overrun_frame();
    logic [7:0] exp_q[$];
    logic [7:0] d;
    int lat;
    for (int k = 0; k < DEPTH + 1; k++) begin
      d = 8'($urandom);
      if (k < DEPTH) exp_q.push_back(d);
      send_rx(d, 1'b1);
      if (k == DEPTH - 1) begin
        n_checks++; if (rxOverrun !== 1'b0) begin n_errors++; $display("FAIL ovr_early got=%b want=0", rxOverrun); end
      end
    end
    n_checks++; if (rxOverrun !== 1'b1) begin n_errors++; $display("FAIL ovr_set got=%b want=1", rxOverrun); end
    n_checks++; if (rxFrameErr !== 1'b0) begin n_errors++; $display("FAIL ferr_early got=%b want=0", rxFrameErr); end
    send_rx(8'($urandom), 1'b0);
    step(4);
    n_checks++; if (rxFrameErr !== 1'b1) begin n_errors++; $display("FAIL ferr_set got=%b want=1", rxFrameErr); end
    for (int k = 0; k < DEPTH; k++) begin
      read_byte(d, lat);
      n_checks++; if (lat < 0 || d !== exp_q[k]) begin n_errors++; $display("FAIL ovr_byte idx=%0d got=%h lat=%0d want=%h", k, d, lat, exp_q[k]); end
    end
    read_byte(d, lat);
    n_checks++; if (lat != -1) begin n_errors++; $display("FAIL ovr_empty_read got_lat=%0d want=-1", lat); end
    n_checks++; if (rxOverrun !== 1'b1 || rxFrameErr !== 1'b1) begin n_errors++; $display("FAIL flags_sticky got=%b%b want=11", rxOverrun, rxFrameErr); end
  endtask

  task automatic test_glitch();
    logic [7:0] d;
    int lat;
    rx = 1'b0;
    step();
    rx = 1'b1;
    step(3 * FRAME);
    read_byte(d, lat);
    n_checks++; if (lat != -1) begin n_errors++; $display("FAIL glitch_byte got_lat=%0d data=%h want no ack", lat, d); end
  endtask

  task automatic test_reset_mid_tx();
    int bad;
    write_byte(8'($urandom_range(0, 127)));
    step(3 * CPB + 3);
    reset = 1'b1;
    step();
    n_checks++; if (tx !== 1'b1) begin n_errors++; $display("FAIL rst_tx got=%b want=1", tx); end
    n_checks++; if (uartWriteReady !== 1'b1) begin n_errors++; $display("FAIL rst_wready got=%b want=1", uartWriteReady); end
    n_checks++; if (rxOverrun !== 1'b0 || rxFrameErr !== 1'b0) begin n_errors++; $display("FAIL rst_flags got=%b%b want=00", rxOverrun, rxFrameErr); end
    n_checks++; if (uartReadData !== 8'h00) begin n_errors++; $display("FAIL rst_rdata got=%h want=00", uartReadData); end
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      step();
      if (tx !== 1'b1) bad++;
    end
    n_checks++; if (bad != 0) begin n_errors++; $display("FAIL rst_no_resume low_cycles=%0d want=0", bad); end
  endtask

  initial begin
    test_reset();
    test_tx_single();
    test_tx_backpressure();
    test_tx_random();
    test_rx_read();
    test_overrun_frame();
    test_glitch();
    test_reset_mid_tx();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
